// File: rtl/apb_mem_slave_pkg.sv
// ============================================================================
// Module   : apb_mem_slave_pkg
// Brief    : Shared widths, FSM state codes and address-check helper for the
//            APB4 memory completer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_mem_slave_pkg;

  localparam int APB_DW = 32;
  localparam int APB_AW = 32;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_state_e;

  // Misaligned, or beyond the window; the unsigned compare also catches
  // addresses below the base because the subtraction wraps to a huge value.
  function automatic logic addr_err(input logic [APB_AW-1:0] addr,
                                    input logic [APB_AW-1:0] offset,
                                    input logic [APB_AW-1:0] limit);
    return (addr[1:0] != 2'b00) || (offset >= limit);
  endfunction

endpackage

`default_nettype wire

// File: rtl/apb_slave_mem.sv
// ============================================================================
// Module   : apb_slave_mem
// Brief    : DEPTH x 32-bit word array, asynchronous clear, one combinational
//            read port and one byte-strobe write port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_slave_mem
  import apb_mem_slave_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [APB_DW-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [3:0]        wr_strb,
  input  logic [APB_DW-1:0] wr_data
);

  logic [APB_DW-1:0] r_mem [DEPTH];

  // Read port is purely combinational; the top registers the result.
  assign rd_data = r_mem[rd_idx];

  // Whole array clears on reset; writes touch only strobed bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) begin
          r_mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/apb_mem_slave.sv
// ============================================================================
// Module   : apb_mem_slave
// Brief    : APB4 completer backed by a DEPTH x 32 memory, with programmable
//            wait states and PSLVERR on misaligned/out-of-window addresses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_mem_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH       = 64,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        apb_clk_i,
  input  logic        apb_reset_i,
  input  logic        apb_clk_en_i,
  input  logic [31:0] apb_addr_i,
  input  logic        apb_sel_i,
  input  logic        apb_enable_i,
  input  logic        apb_write_i,
  input  logic [3:0]  apb_strb_i,
  input  logic [2:0]  apb_prot_i,
  input  logic [31:0] apb_wdata_i,
  output logic        apb_ready_o,
  output logic [31:0] apb_rdata_o,
  output logic        apb_slverr_o
);

  import apb_mem_slave_pkg::*;

  localparam int          IDX_W   = $clog2(DEPTH);
  localparam logic [31:0] C_LIMIT = 32'(4 * DEPTH);
  localparam logic [3:0]  C_WAIT  = 4'(WAIT_CYCLES);

  apb_state_e        r_state, w_state_nxt;
  logic [3:0]        r_wcnt, w_wcnt_nxt;
  logic              r_err, w_err_nxt;
  logic              r_write, w_write_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  logic [APB_DW-1:0] r_rdata, w_rdata_nxt;

  logic [APB_AW-1:0] w_offset;
  logic [IDX_W-1:0]  w_idx_dec;
  logic              w_err_dec;
  logic [APB_DW-1:0] w_mem_rdata;
  logic              w_mem_we;
  logic              w_ready;
  logic              w_unused_prot;

  // PPROT carries no meaning for this memory.
  assign w_unused_prot = ^apb_prot_i;

  // Address decode for the setup phase.
  assign w_offset  = apb_addr_i - BASE_ADDR;
  assign w_idx_dec = w_offset[IDX_W+1:2];
  assign w_err_dec = addr_err(apb_addr_i, w_offset, C_LIMIT);

  // Outputs depend only on registers.
  assign w_ready      = (r_state == ST_ACCESS) && (r_wcnt == 4'd0);
  assign apb_ready_o  = w_ready;
  assign apb_slverr_o = w_ready & r_err;
  assign apb_rdata_o  = r_rdata;

  apb_slave_mem #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_mem (
    .clk     (apb_clk_i),
    .rst     (apb_reset_i),
    .rd_idx  (w_idx_dec),
    .rd_data (w_mem_rdata),
    .wr_en   (w_mem_we & apb_clk_en_i),
    .wr_idx  (r_idx),
    .wr_strb (apb_strb_i),
    .wr_data (apb_wdata_i)
  );

  // Next-state, wait counter, latched decode and memory write strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_err_nxt   = r_err;
    w_write_nxt = r_write;
    w_idx_nxt   = r_idx;
    w_rdata_nxt = r_rdata;
    w_mem_we    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (apb_sel_i && !apb_enable_i) begin
          w_state_nxt = ST_ACCESS;
          w_wcnt_nxt  = C_WAIT;
          w_err_nxt   = w_err_dec;
          w_write_nxt = apb_write_i;
          w_idx_nxt   = w_idx_dec;
          w_rdata_nxt = (!apb_write_i && !w_err_dec) ? w_mem_rdata : '0;
        end
      end
      ST_ACCESS: begin
        if (!apb_sel_i) begin
          w_state_nxt = ST_IDLE;
          w_wcnt_nxt  = 4'd0;
          w_err_nxt   = 1'b0;
          w_rdata_nxt = '0;
        end else if (r_wcnt != 4'd0) begin
          w_wcnt_nxt = r_wcnt - 4'd1;
        end else if (apb_enable_i) begin
          w_state_nxt = ST_IDLE;
          w_err_nxt   = 1'b0;
          w_rdata_nxt = '0;
          w_mem_we    = r_write && !r_err;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State registers advance only on qualified edges.
  always_ff @(posedge apb_clk_i or posedge apb_reset_i) begin
    if (apb_reset_i) begin
      r_state <= ST_IDLE;
      r_wcnt  <= 4'd0;
      r_err   <= 1'b0;
      r_write <= 1'b0;
      r_idx   <= '0;
      r_rdata <= '0;
    end else if (apb_clk_en_i) begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_err   <= w_err_nxt;
      r_write <= w_write_nxt;
      r_idx   <= w_idx_nxt;
      r_rdata <= w_rdata_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_apb_mem_slave.sv
// ============================================================================
// Module   : tb_apb_mem_slave
// Brief    : Directed self-checking bench; three completers with 0, 3 and 2
//            wait states share one APB bus, each with its own PSEL.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_mem_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b1;
  logic [31:0] addr = '0;
  logic        enable = 1'b0;
  logic        write = 1'b0;
  logic [3:0]  strb = '0;
  logic [2:0]  prot = '0;
  logic [31:0] wdata = '0;
  logic        sel [3];
  logic        rdy [3];
  logic        serr [3];
  logic [31:0] rdat [3];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  apb_mem_slave #(.BASE_ADDR(32'h0), .DEPTH(64), .WAIT_CYCLES(0)) u_dut0 (
    .apb_clk_i(clk), .apb_reset_i(rst), .apb_clk_en_i(clk_en), .apb_addr_i(addr),
    .apb_sel_i(sel[0]), .apb_enable_i(enable), .apb_write_i(write), .apb_strb_i(strb),
    .apb_prot_i(prot), .apb_wdata_i(wdata), .apb_ready_o(rdy[0]), .apb_rdata_o(rdat[0]),
    .apb_slverr_o(serr[0]));

  apb_mem_slave #(.BASE_ADDR(32'h0), .DEPTH(64), .WAIT_CYCLES(3)) u_dut1 (
    .apb_clk_i(clk), .apb_reset_i(rst), .apb_clk_en_i(clk_en), .apb_addr_i(addr),
    .apb_sel_i(sel[1]), .apb_enable_i(enable), .apb_write_i(write), .apb_strb_i(strb),
    .apb_prot_i(prot), .apb_wdata_i(wdata), .apb_ready_o(rdy[1]), .apb_rdata_o(rdat[1]),
    .apb_slverr_o(serr[1]));

  apb_mem_slave #(.BASE_ADDR(32'h0), .DEPTH(64), .WAIT_CYCLES(2)) u_dut2 (
    .apb_clk_i(clk), .apb_reset_i(rst), .apb_clk_en_i(clk_en), .apb_addr_i(addr),
    .apb_sel_i(sel[2]), .apb_enable_i(enable), .apb_write_i(write), .apb_strb_i(strb),
    .apb_prot_i(prot), .apb_wdata_i(wdata), .apb_ready_o(rdy[2]), .apb_rdata_o(rdat[2]),
    .apb_slverr_o(serr[2]));

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One complete transfer on completer d. cycles counts from the setup cycle
  // (1) to the cycle in which ready is seen high. With stall set, clk_en is
  // dropped for 4 cycles at the first access cycle while outputs are checked.
  task automatic apb_xfer(input int d, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] st,
                          input logic stall, input logic [31:0] exp_hold,
                          output logic [31:0] rd, output logic er, output int cycles);
    logic done;
    @(posedge clk); #1;
    sel[d] = 1'b1; enable = 1'b0; write = wr; addr = a; wdata = wd; strb = st;
    cycles = 1;
    @(posedge clk); #1;
    enable = 1'b1;
    cycles = 2;
    if (stall) begin
      clk_en = 1'b0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        check_val("stall_ready", 32'(rdy[d]), 32'd0);
        check_val("stall_rdata", rdat[d], exp_hold);
        @(posedge clk); #1;
        cycles++;
      end
      clk_en = 1'b1;
    end
    done = 1'b0;
    rd = '0;
    er = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (rdy[d]) begin
        rd = rdat[d];
        er = serr[d];
        done = 1'b1;
      end else begin
        @(posedge clk); #1;
        cycles++;
      end
    end
    if (!done) check_val("ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    sel[d] = 1'b0; enable = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          cyc;

  initial begin
    for (int i = 0; i < 3; i++) sel[i] = 1'b0;

    // Reset state
    #2;
    for (int i = 0; i < 3; i++) begin
      check_val("rst_ready", 32'(rdy[i]), 32'd0);
      check_val("rst_rdata", rdat[i], 32'd0);
      check_val("rst_slverr", 32'(serr[i]), 32'd0);
    end
    @(posedge clk); #1; rst = 1'b0;

    // Zero-wait write then read
    apb_xfer(0, 1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, rd, er, cyc);
    check_val("t1_wr_cycles", 32'(cyc), 32'd2);
    check_val("t1_wr_slverr", 32'(er), 32'd0);
    apb_xfer(0, 1'b0, 32'h08, 32'h0, 4'h0, 1'b0, 32'h0, rd, er, cyc);
    check_val("t1_rd_cycles", 32'(cyc), 32'd2);
    check_val("t1_rd_data", rd, 32'hDEADBEEF);
    check_val("t1_rd_slverr", 32'(er), 32'd0);
    @(negedge clk);
    check_val("t1_idle_ready", 32'(rdy[0]), 32'd0);
    check_val("t1_idle_rdata", rdat[0], 32'd0);

    // Byte strobes
    apb_xfer(0, 1'b1, 32'h04, 32'hFFFFFFFF, 4'b0101, 1'b0, 32'h0, rd, er, cyc);
    apb_xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, 1'b0, 32'h0, rd, er, cyc);
    check_val("t2_strb_data", rd, 32'h00FF00FF);
    apb_xfer(0, 1'b1, 32'h08, 32'h11111111, 4'b0000, 1'b0, 32'h0, rd, er, cyc);
    apb_xfer(0, 1'b0, 32'h08, 32'h0, 4'h0, 1'b0, 32'h0, rd, er, cyc);
    check_val("t2_strb0_data", rd, 32'hDEADBEEF);

    // Last word of the window
    apb_xfer(0, 1'b1, 32'hFC, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0, rd, er, cyc);
    check_val("top_wr_slverr", 32'(er), 32'd0);
    apb_xfer(0, 1'b0, 32'hFC, 32'h0, 4'h0, 1'b0, 32'h0, rd, er, cyc);
    check_val("top_rd_data", rd, 32'hCAFEF00D);

    // Error responses
    apb_xfer(0, 1'b0, 32'h100, 32'h0, 4'h0, 1'b0, 32'h0, rd, er, cyc);
    check_val("t4_oob_slverr", 32'(er), 32'd1);
    check_val("t4_oob_rdata", rd, 32'd0);
    check_val("t4_oob_cycles", 32'(cyc), 32'd2);
    apb_xfer(0, 1'b1, 32'h0A, 32'h12345678, 4'hF, 1'b0, 32'h0, rd, er, cyc);
    check_val("t4_mis_slverr", 32'(er), 32'd1);
    check_val("t4_mis_rdata", rd, 32'd0);
    apb_xfer(0, 1'b0, 32'h08, 32'h0, 4'h0, 1'b0, 32'h0, rd, er, cyc);
    check_val("t4_mem_kept", rd, 32'hDEADBEEF);

    // Three wait states
    apb_xfer(1, 1'b1, 32'h00, 32'h0BADF00D, 4'hF, 1'b0, 32'h0, rd, er, cyc);
    check_val("t3_wr_cycles", 32'(cyc), 32'd5);
    apb_xfer(1, 1'b0, 32'h00, 32'h0, 4'h0, 1'b0, 32'h0, rd, er, cyc);
    check_val("t3_rd_cycles", 32'(cyc), 32'd5);
    check_val("t3_rd_data", rd, 32'h0BADF00D);

    // Abort by dropping sel in access: no write
    @(posedge clk); #1;
    sel[1] = 1'b1; enable = 1'b0; write = 1'b1; addr = 32'h0C; wdata = 32'h11112222; strb = 4'hF;
    @(posedge clk); #1; enable = 1'b1;
    @(posedge clk); #1; sel[1] = 1'b0; enable = 1'b0;
    @(negedge clk);
    check_val("abort_ready", 32'(rdy[1]), 32'd0);
    apb_xfer(1, 1'b0, 32'h0C, 32'h0, 4'h0, 1'b0, 32'h0, rd, er, cyc);
    check_val("abort_nowrite", rd, 32'd0);

    // Clock-enable stall during a 2-wait-state read
    apb_xfer(2, 1'b1, 32'h20, 32'hA5A50F0F, 4'hF, 1'b0, 32'h0, rd, er, cyc);
    check_val("t5_wr_cycles", 32'(cyc), 32'd4);
    apb_xfer(2, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1, 32'hA5A50F0F, rd, er, cyc);
    check_val("t5_rd_cycles", 32'(cyc), 32'd8);
    check_val("t5_rd_data", rd, 32'hA5A50F0F);

    // IDLE ignores sel=1,enable=1 without a setup phase
    @(posedge clk); #1; sel[0] = 1'b1; enable = 1'b1; write = 1'b0; addr = 32'h08;
    @(posedge clk); #1;
    @(negedge clk);
    check_val("idle_viol_ready", 32'(rdy[0]), 32'd0);
    @(posedge clk); #1; sel[0] = 1'b0; enable = 1'b0;

    // Reset in the access phase of a write
    @(posedge clk); #1;
    sel[0] = 1'b1; enable = 1'b0; write = 1'b1; addr = 32'h10; wdata = 32'h55AA55AA; strb = 4'hF;
    @(posedge clk); #1; enable = 1'b1;
    @(negedge clk);
    check_val("t6_pre_ready", 32'(rdy[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_val("t6_ready", 32'(rdy[0]), 32'd0);
    check_val("t6_slverr", 32'(serr[0]), 32'd0);
    check_val("t6_rdata", rdat[0], 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_val("t6_idle_ready", 32'(rdy[0]), 32'd0);
    @(posedge clk); #1; sel[0] = 1'b0; enable = 1'b0;
    apb_xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'h0, rd, er, cyc);
    check_val("t6_rd_10", rd, 32'd0);
    apb_xfer(0, 1'b0, 32'h08, 32'h0, 4'h0, 1'b0, 32'h0, rd, er, cyc);
    check_val("t6_rd_cleared", rd, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
